// File: rtl/axis_cfg_sink.sv
// Config-table consumer: turns 16-bit {reg_addr, reg_data} words into 3-byte I2C write frames
// (DEV_ADDR, reg_addr, reg_data) on a byte stream, with in-band delay and end-of-table words.
`timescale 1ns/1ps
module axis_cfg_sink #(
  parameter logic [7:0]  DEV_ADDR   = 8'h42,
  parameter logic [15:0] END_WORD   = 16'hFFFF,
  parameter logic [7:0]  DELAY_CODE = 8'hF0,
  parameter int          DELAY_TICK = 1000,
  parameter int          MAX_WORDS  = 24,
  localparam int         CNT_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             start_i,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [15:0]      s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [2:0]       dbg_state_o
);

  localparam int DLY_W = $clog2(255 * DELAY_TICK + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    DELAY = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_word, w_word_nxt;
  logic [1:0]         r_beat, w_beat_nxt;
  logic [DLY_W-1:0]   r_dly_cnt, w_dly_nxt;
  logic [CNT_W-1:0]   r_word_cnt, w_cnt_nxt;
  logic               r_err, w_err_nxt;
  logic               w_s_hs;
  logic               w_m_hs;

  // Both streams use AXI-Stream valid/ready: a beat transfers on a rising edge where tvalid
  // and tready are both high; once raised, tvalid/tdata/tlast hold until that transfer.
  assign s_axis_tready = (r_state == FETCH);
  assign m_axis_tvalid = (r_state == SEND);
  assign m_axis_tlast  = (r_state == SEND) && (r_beat == 2'd2);
  assign busy_o        = (r_state != IDLE);
  assign done_o        = (r_state == DONE);
  assign err_o         = r_err;
  assign word_cnt_o    = r_word_cnt;
  assign dbg_state_o   = r_state;

  assign w_s_hs = s_axis_tvalid && s_axis_tready;
  assign w_m_hs = m_axis_tvalid && m_axis_tready;

  always_comb begin
    m_axis_tdata = 8'h00;
    if (r_state == SEND) begin
      case (r_beat)
        2'd0:    m_axis_tdata = DEV_ADDR;
        2'd1:    m_axis_tdata = r_word[15:8];
        default: m_axis_tdata = r_word[7:0];
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_beat_nxt  = r_beat;
    w_dly_nxt   = r_dly_cnt;
    w_cnt_nxt   = r_word_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = FETCH;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      FETCH: begin
        if (w_s_hs) begin
          w_word_nxt = s_axis_tdata;
          w_cnt_nxt  = r_word_cnt + CNT_W'(1);
          // End marker wins over both the word limit and the delay code.
          if (s_axis_tdata == END_WORD) begin
            w_state_nxt = DONE;
          end else if (r_word_cnt == CNT_W'(MAX_WORDS - 1)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else if (s_axis_tdata[15:8] == DELAY_CODE) begin
            w_dly_nxt   = DLY_W'(s_axis_tdata[7:0]) * DLY_W'(DELAY_TICK);
            w_state_nxt = DELAY;
          end else begin
            w_beat_nxt  = 2'd0;
            w_state_nxt = SEND;
          end
        end
      end
      SEND: begin
        if (w_m_hs) begin
          if (r_beat == 2'd2) begin
            w_beat_nxt  = 2'd0;
            w_state_nxt = FETCH;
          end else begin
            w_beat_nxt = r_beat + 2'd1;
          end
        end
      end
      DELAY: begin
        // Leaving on a count of 1 gives N*TICK cycles here; a zero count still spends one.
        if (r_dly_cnt <= DLY_W'(1)) w_state_nxt = FETCH;
        if (r_dly_cnt != '0) w_dly_nxt = r_dly_cnt - DLY_W'(1);
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state    <= IDLE;
      r_word     <= 16'h0000;
      r_beat     <= 2'd0;
      r_dly_cnt  <= '0;
      r_word_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_beat     <= w_beat_nxt;
      r_dly_cnt  <= w_dly_nxt;
      r_word_cnt <= w_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_axis_cfg_sink.sv
// Bench for axis_cfg_sink: table of config words with hand-computed frames, plus directed
// sequences for delay timing, start while busy, and reset in the middle of a frame.
`timescale 1ns/1ps
module tb_axis_cfg_sink;

  localparam int MAXW  = 4;
  localparam int TICK  = 4;
  localparam int CNT_W = $clog2(MAXW + 1);

  logic             clk_i = 1'b0;
  logic             arstn_i;
  logic             start_i;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [15:0]      s_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b0;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tlast;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [CNT_W-1:0] word_cnt_o;
  logic [2:0]       dbg_state_o;

  axis_cfg_sink #(
    .DEV_ADDR   (8'h42),
    .END_WORD   (16'hFFFF),
    .DELAY_CODE (8'hF0),
    .DELAY_TICK (TICK),
    .MAX_WORDS  (MAXW)
  ) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .start_i       (start_i),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .word_cnt_o    (word_cnt_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];          // {tlast, tdata} of each expected m_axis beat
  int         tr_mode = 0;       // 0: tready high, 1: toggling, 2: held low
  logic       tog = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream sink: drives tready on falling edges and logs the beat taken at the next rise.
  always @(negedge clk_i) begin
    if (prev_stall && arstn_i) begin
      chk("m_hold_valid", 32'(m_axis_tvalid), 32'd1);
      chk("m_hold_data", 32'(m_axis_tdata), 32'(prev_data));
      chk("m_hold_last", 32'(m_axis_tlast), 32'(prev_last));
    end
    tog = ~tog;
    case (tr_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = tog;
      default: m_axis_tready = 1'b0;
    endcase
    if (arstn_i && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_unexpected_beat: got data %0h last %0b, required no beat", m_axis_tdata, m_axis_tlast);
      end else begin
        chk("m_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp_q.pop_front()));
      end
    end
    prev_stall = arstn_i && m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
  end

  // ---------------- driver tasks ----------------
  task automatic set_mode(input int m);
    @(posedge clk_i);
    #1 tr_mode = m;
  endtask

  task automatic push_frame(input logic [7:0] b1, input logic [7:0] b2);
    exp_q.push_back({1'b0, 8'h42});
    exp_q.push_back({1'b0, b1});
    exp_q.push_back({1'b1, b2});
  endtask

  task automatic do_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    int n = 0;
    @(negedge clk_i);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = w;
    while (!s_axis_tready && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (!s_axis_tready) begin
      checks++;
      errors++;
      $display("FAIL s_hs_timeout: tready low for %0d cycles on word %0h, required high", n, w);
      s_axis_tvalid = 1'b0;
    end else begin
      @(negedge clk_i);
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic wait_done(input int exp_cnt, input logic exp_err);
    int n = 0;
    while (!done_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk("done_seen", 32'(done_o), 32'd1);
    chk("word_cnt", 32'(word_cnt_o), 32'(exp_cnt));
    chk("err", 32'(err_o), 32'(exp_err));
    chk("busy_in_done", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk("busy_after_done", 32'(busy_o), 32'd0);
    chk("word_cnt_hold", 32'(word_cnt_o), 32'(exp_cnt));
    chk("err_hold", 32'(err_o), 32'(exp_err));
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_start();
    chk("busy_after_start", 32'(busy_o), 32'd1);
    chk("cnt_cleared", 32'(word_cnt_o), 32'd0);
    chk("err_cleared", 32'(err_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    chk({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_m_tdata"}, 32'(m_axis_tdata), 32'd0);
    chk({tag, "_m_tlast"}, 32'(m_axis_tlast), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_cnt"}, 32'(word_cnt_o), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state_o), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] word;
    logic        frame;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          mode;
    logic        last;
    int          exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int   n;
    logic saw;
    logic need_start;

    tbl[0] = '{16'h1280, 1'b1, 8'h12, 8'h80, 0, 1'b0, 0, 1'b0};
    tbl[1] = '{16'hFFFF, 1'b0, 8'h00, 8'h00, 0, 1'b1, 2, 1'b0};
    tbl[2] = '{16'hA5C3, 1'b1, 8'hA5, 8'hC3, 1, 1'b0, 0, 1'b0};
    tbl[3] = '{16'hF002, 1'b0, 8'h00, 8'h00, 1, 1'b0, 0, 1'b0};
    tbl[4] = '{16'h0E7F, 1'b1, 8'h0E, 8'h7F, 1, 1'b0, 0, 1'b0};
    tbl[5] = '{16'hFFFF, 1'b0, 8'h00, 8'h00, 1, 1'b1, 4, 1'b0};
    tbl[6] = '{16'h0101, 1'b1, 8'h01, 8'h01, 0, 1'b0, 0, 1'b0};
    tbl[7] = '{16'h0101, 1'b1, 8'h01, 8'h01, 0, 1'b0, 0, 1'b0};
    tbl[8] = '{16'h0101, 1'b1, 8'h01, 8'h01, 0, 1'b0, 0, 1'b0};
    tbl[9] = '{16'h0101, 1'b0, 8'h00, 8'h00, 0, 1'b1, 4, 1'b1};

    // ---------------- reset ----------------
    arstn_i       = 1'b0;
    start_i       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 16'h0000;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk_i);
    #1 arstn_i = 1'b1;

    // ---------------- table-driven sequences ----------------
    need_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (need_start) begin
        do_start();
        check_start();
        need_start = 1'b0;
      end
      set_mode(tbl[i].mode);
      if (tbl[i].frame) push_frame(tbl[i].b1, tbl[i].b2);
      send_word(tbl[i].word);
      if (tbl[i].last) begin
        wait_done(tbl[i].exp_cnt, tbl[i].exp_err);
        need_start = 1'b1;
      end
    end

    // ---------------- delay timing: 3*TICK cycles, then count 0 ----------------
    set_mode(0);
    do_start();
    check_start();
    send_word(16'hF003);
    n = 0;
    saw = 1'b0;
    while (!s_axis_tready && n < 100) begin
      if (m_axis_tvalid) saw = 1'b1;
      @(negedge clk_i);
      n++;
    end
    chk("delay3_cycles", 32'(n), 32'd12);
    chk("delay3_no_m_traffic", 32'(saw), 32'd0);
    chk("delay3_then_fetch", 32'(dbg_state_o), 32'd1);
    send_word(16'hF000);
    n = 0;
    while (!s_axis_tready && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("delay0_cycles", 32'(n), 32'd1);
    send_word(16'hFFFF);
    wait_done(3, 1'b0);

    // ---------------- start re-pulsed while busy ----------------
    set_mode(2);
    do_start();
    check_start();
    push_frame(8'h12, 8'h80);
    send_word(16'h1280);
    do_start();
    chk("restart_busy", 32'(busy_o), 32'd1);
    chk("restart_cnt", 32'(word_cnt_o), 32'd1);
    chk("restart_state_send", 32'(dbg_state_o), 32'd2);
    set_mode(0);
    send_word(16'hFFFF);
    wait_done(2, 1'b0);

    // ---------------- reset while beat 2 is stalled ----------------
    set_mode(2);
    do_start();
    check_start();
    exp_q.push_back({1'b0, 8'h42});
    send_word(16'h1234);
    @(posedge clk_i);
    #1 tr_mode = 0;
    @(posedge clk_i);
    #1 tr_mode = 2;
    @(negedge clk_i);
    chk("midframe_valid", 32'(m_axis_tvalid), 32'd1);
    chk("midframe_beat2", 32'(m_axis_tdata), 32'h12);
    chk("midframe_last", 32'(m_axis_tlast), 32'd0);
    #1 arstn_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    chk("midrst_q_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk_i);
    @(posedge clk_i);
    #1 arstn_i = 1'b1;

    // ---------------- clean run after reset ----------------
    set_mode(0);
    do_start();
    check_start();
    push_frame(8'h12, 8'h80);
    send_word(16'h1280);
    send_word(16'hFFFF);
    wait_done(2, 1'b0);

    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
